// File: rtl/zwave_uart_pkg.sv
// Shared constants for the Z-Wave UART receiver: default timing, FSM state encodings,
// and helpers that derive the bit-timer geometry from the clocks-per-bit setting.
package zwave_uart_pkg;

    localparam int DEF_CLK_PER_BIT = 432;
    localparam int DEF_FIFO_AW     = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    function automatic int half_bit(input int clk_per_bit);
        return clk_per_bit / 2;
    endfunction

    function automatic int timer_w(input int clk_per_bit);
        return $clog2(clk_per_bit);
    endfunction

endpackage

// File: rtl/zwave_uart_rx_fifo.sv
// First-word-fall-through byte FIFO. A push lands on dout/count one cycle later.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            // Storage is cleared too so the head reads 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zwave_uart_rx.sv
// 8N1 receiver for the Z-Wave link feeding a FWFT FIFO; byte visible 2 cycles after stop sample.
// No backpressure on the line: bytes arriving while the FIFO is full are dropped and flagged.
module zwave_uart_rx
    import zwave_uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int FIFO_AW     = DEF_FIFO_AW
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               zwave_rxd,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               clr_err,
    output logic               irq
);

    localparam int              TW     = timer_w(CLK_PER_BIT);
    localparam logic [TW-1:0]   T_HALF = TW'(half_bit(CLK_PER_BIT) - 1);
    localparam logic [TW-1:0]   T_FULL = TW'(CLK_PER_BIT - 1);

    logic          sync1;
    logic          rxs;
    logic          rxs_d;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push;
    logic          stop_bad;
    logic          drop;

    // Timer is zeroed at each sample point so the next one lands one bit later.
    always_ff @(posedge clk) begin
        if (resetn) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            push    <= 1'b0;
        end else begin
            sync1 <= zwave_rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
            push  <= 1'b0;
            timer <= timer + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (rxs_d && !rxs) begin
                        timer <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer == T_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (timer == T_FULL) begin
                        timer   <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (timer == T_FULL) begin
                        timer <= '0;
                        if (rxs) begin
                            push  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stop_bad = (state == ST_STOP) && (timer == T_FULL) && !rxs;
    assign drop     = push && full && !rd_en;

    // A new error in the same cycle as clr_err takes precedence.
    always_ff @(posedge clk) begin
        if (resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (shreg),
        .pop    (rd_en),
        .dout   (rd_data),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    assign irq = ~empty;

endmodule

// File: doc/zwave_uart_rx.md
Name: zwave_uart_rx

Overview:
- 8N1 UART receiver for the Z-Wave radio link on the zwave_rxd pin, with a receive FIFO.
- Sits between the pad and the SPI-bus register file. The RPi drains received bytes through a pop-style read port.
- Default timing: 50 MHz system clock, 432 clocks per bit (~115.7 kbaud).

Parameters:
- CLK_PER_BIT, 432, system clocks per UART bit; must be at least 16.
- FIFO_AW, 4, FIFO address width; depth is 2**FIFO_AW = 16 bytes.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-high reset (asserted = 1), sampled on the rising edge of clk
- zwave_rxd  in  1  asynchronous serial input; idles high
- rd_en  in  1  pop strobe, one byte per cycle asserted
- rd_data  out  8  FIFO head byte (first-word fall-through)
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  FIFO_AW+1  bytes held, 0..16
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte arrived while FIFO full
- clr_err  in  1  clears frame_err and overrun
- irq  out  1  equals ~empty

Behaviour:
- Reset values: FIFO pointers = 0, count = 0, empty = 1, full = 0, rd_data = 0, frame_err = 0, overrun = 0, irq = 0. Synchronizer flops are set to 1 and the FSM goes to IDLE.
- Reset mid-frame aborts the frame; no partial byte is stored.
- Input path: 2-flop synchronizer; rxs is the synchronized signal. A falling edge is detected from rxs and its one-cycle-delayed copy.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A bit timer counts 0..CLK_PER_BIT-1; a bit index counts 0..7.
- IDLE: on a falling edge of rxs in cycle t0, load timer and go to START.
- START: sample rxs at t0 + CLK_PER_BIT/2 (integer division).
  - If rxs = 1: false start, return to IDLE; no flags change.
  - Otherwise go to DATA.
- DATA: sample bit k (k = 0..7, LSB first) at t0 + CLK_PER_BIT/2 + (k+1)*CLK_PER_BIT, shifting into the shift register. After k = 7 go to STOP.
- STOP: sample at t0 + CLK_PER_BIT/2 + 9*CLK_PER_BIT.
  - rxs = 1: push the byte and return to IDLE immediately (mid stop bit), so back-to-back frames are captured.
  - rxs = 0: set frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: wait for rxs = 1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Push latency: the push happens in the cycle after the stop sample. The byte is visible on rd_data, empty and count one cycle after that.
- FIFO rules:
  - Push while full and no pop: byte dropped, overrun set.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overrun.
  - Pop while empty: ignored; count stays 0 and pointers are unchanged.
  - Pointers wrap modulo 2**FIFO_AW; full/empty are derived from count.
- rd_data always shows the head entry. After a pop it updates to the next entry on the following cycle.
- Error clearing: clr_err clears both sticky flags. If clr_err and a new error occur in the same cycle, the set wins.

Decomposition:
- Package zwave_uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - HALF_BIT = CLK_PER_BIT/2.
  - Bit-timer width = clog2(CLK_PER_BIT).
- Sub-module uart_rx_fifo: a synchronous FWFT FIFO. Ports: clk, resetn, push, din, pop, dout, count, empty, full.
- The FSM, synchronizer and error flags live in the top module.

Test Plan:
- Single frame: after reset, send 0xAA at 432 clk/bit with stop high. Required: empty falls within 2 cycles of the stop-bit midpoint, rd_data = 0xAA, count = 1. After one rd_en: empty = 1, count = 0.
- Back-to-back frames: send 0xAA, 0xAB, 0xAC with a one-bit stop and no idle gap. Required: reads return 0xAA, 0xAB, 0xAC in order; no flags set.
- Glitch rejection: drive a 100-cycle low pulse on idle zwave_rxd. Required: FSM returns to IDLE, count = 0, frame_err = 0.
- Framing error: send 0x55 with a low stop bit, then hold low for 20 bit times, then high. Required: frame_err = 1 exactly once, count = 0. After clr_err, frame_err = 0 and the next valid 0x3C is received.
- Overrun and wrap: send 0x00..0x10 (17 bytes) without reading. Required: full = 1 and count = 16 after byte 16; overrun = 1 after byte 17. Reads return 0x00..0x0F, then empty = 1.
- Reset mid-frame: assert resetn for 1 cycle during bit 4 of a frame, then send 0x5A. Required: only 0x5A is stored, and all flags are 0.
